// File: rtl/hub_sched_pkg.sv
// Shared types and constants for the hub slot scheduler.
// The reset table reproduces the legacy rotation cog0..cog7.
package hub_sched_pkg;

  localparam int unsigned NUM_COGS  = 8;
  localparam int unsigned TBL_DEPTH = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned COG_W     = 3;

  localparam logic [IDX_W-1:0] LEN_RESET = 4'd7;
  localparam logic [IDX_W-1:0] IDX_RESET = 4'd15;

  typedef struct packed {
    logic             valid;
    logic [COG_W-1:0] cog;
  } slot_entry_t;

  // Entry i owns cog i mod 8, so the default table rotates through all cogs.
  function automatic slot_entry_t reset_entry(input logic [IDX_W-1:0] i);
    slot_entry_t e;
    e.valid = 1'b1;
    e.cog   = i[COG_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/hub_slot_sched_rr_pick8.sv
// Rotating-priority picker: first set bit of req searching upward from ptr,
// wrapping from 7 back to 0.
module rr_pick8
  import hub_sched_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       hit,
  output logic [2:0] idx
);

  logic [2:0] cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_COGS; k++) begin
      cand = ptr + 3'(k);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/hub_slot_sched.sv
// Hub access scheduler: walks a programmable slot table on every bus phase
// and issues a one-hot cog select, optionally donating unusable slots.
module hub_slot_sched
  import hub_sched_pkg::*;
(
  input  logic       clk_cog,
  input  logic       nres,
  input  logic [7:0] cog_ena,
  input  logic [7:0] cog_req,
  input  logic       mode_skip,
  input  logic       tbl_we,
  input  logic [3:0] tbl_addr,
  input  logic [3:0] tbl_data,
  input  logic       len_we,
  input  logic [3:0] len_data,
  output logic       ena_bus,
  output logic [7:0] bus_sel,
  output logic [3:0] slot_idx,
  output logic       donated
);

  logic             ena_bus_q,  ena_bus_d;
  logic [7:0]       bus_sel_q,  bus_sel_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic             donated_q,  donated_d;
  logic [IDX_W-1:0] len_q,      len_d;
  logic [COG_W-1:0] don_ptr_q,  don_ptr_d;
  slot_entry_t      tbl_q [TBL_DEPTH];
  slot_entry_t      tbl_d [TBL_DEPTH];

  logic [IDX_W-1:0] nxt_idx_c;
  slot_entry_t      entry_c;
  logic [7:0]       cand_c;
  logic             pick_hit;
  logic [COG_W-1:0] pick_idx;

  assign cand_c = cog_req & cog_ena;

  rr_pick8 u_pick (
    .req (cand_c),
    .ptr (don_ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  // Slot advance and owner selection; only acts on bus-phase edges.
  always_comb begin
    ena_bus_d  = ~ena_bus_q;
    bus_sel_d  = bus_sel_q;
    slot_idx_d = slot_idx_q;
    donated_d  = donated_q;
    don_ptr_d  = don_ptr_q;
    nxt_idx_c  = (slot_idx_q >= len_q) ? '0 : slot_idx_q + 4'd1;
    entry_c    = tbl_q[nxt_idx_c];

    if (ena_bus_q) begin
      slot_idx_d = nxt_idx_c;
      bus_sel_d  = '0;
      donated_d  = 1'b0;
      if (entry_c.valid && cog_ena[entry_c.cog]) begin
        bus_sel_d = 8'(1) << entry_c.cog;
      end else if (mode_skip && pick_hit) begin
        bus_sel_d = 8'(1) << pick_idx;
        donated_d = 1'b1;
        don_ptr_d = pick_idx + 3'd1;
      end
    end
  end

  // Table and length writes; an advance on the same edge sees the old values.
  always_comb begin
    len_d = len_we ? len_data : len_q;
    for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (tbl_we) begin
      tbl_d[tbl_addr] = slot_entry_t'(tbl_data);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      ena_bus_q  <= 1'b0;
      bus_sel_q  <= '0;
      slot_idx_q <= IDX_RESET;
      donated_q  <= 1'b0;
      len_q      <= LEN_RESET;
      don_ptr_q  <= '0;
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= reset_entry(4'(i));
      end
    end else begin
      ena_bus_q  <= ena_bus_d;
      bus_sel_q  <= bus_sel_d;
      slot_idx_q <= slot_idx_d;
      donated_q  <= donated_d;
      len_q      <= len_d;
      don_ptr_q  <= don_ptr_d;
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign ena_bus  = ena_bus_q;
  assign bus_sel  = bus_sel_q;
  assign slot_idx = slot_idx_q;
  assign donated  = donated_q;

endmodule

// File: tb/tb_hub_slot_sched.sv
// Self-checking bench for hub_slot_sched: directed scenarios plus random
// traffic, all compared against a slot-level reference model.
module tb_hub_slot_sched;

  logic       clk_cog = 1'b0;
  logic       nres;
  logic [7:0] cog_ena, cog_req;
  logic       mode_skip, tbl_we, len_we;
  logic [3:0] tbl_addr, tbl_data, len_data;
  logic       ena_bus, donated;
  logic [7:0] bus_sel;
  logic [3:0] slot_idx;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] m_tbl [16];
  int         m_len, m_slot, m_ptr;
  bit         m_ena, m_adv, m_don;
  logic [7:0] m_sel;

  hub_slot_sched dut (
    .clk_cog  (clk_cog),
    .nres     (nres),
    .cog_ena  (cog_ena),
    .cog_req  (cog_req),
    .mode_skip(mode_skip),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .len_we   (len_we),
    .len_data (len_data),
    .ena_bus  (ena_bus),
    .bus_sel  (bus_sel),
    .slot_idx (slot_idx),
    .donated  (donated)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = {1'b1, 3'(i % 8)};
    m_len = 7; m_slot = 15; m_ptr = 0;
    m_ena = 0; m_adv = 0; m_don = 0; m_sel = 8'h00;
  endtask

  // One clock edge of the scheduler, described at the slot level.
  task automatic model_edge();
    int nxt, c, w;
    m_adv = 0;
    if (!nres) return;
    if (m_ena) begin
      m_adv = 1;
      nxt = (m_slot >= m_len) ? 0 : m_slot + 1;
      c = int'(m_tbl[nxt][2:0]);
      m_sel = 8'h00;
      m_don = 0;
      if (m_tbl[nxt][3] && cog_ena[c]) begin
        m_sel = 8'h01 << c;
      end else if (mode_skip) begin
        w = -1;
        for (int k = 0; k < 8; k++) begin
          if (w < 0 && cog_req[(m_ptr + k) % 8] && cog_ena[(m_ptr + k) % 8])
            w = (m_ptr + k) % 8;
        end
        if (w >= 0) begin
          m_sel = 8'h01 << w;
          m_don = 1;
          m_ptr = (w + 1) % 8;
        end
      end
      m_slot = nxt;
    end
    if (tbl_we) m_tbl[tbl_addr] = tbl_data;
    if (len_we) m_len = int'(len_data);
    m_ena = !m_ena;
  endtask

  // Advance one clock (called and returning at a falling edge) and compare.
  task automatic cyc();
    @(posedge clk_cog);
    model_edge();
    #1;
    checks++;
    if (ena_bus !== m_ena) begin
      errors++; $display("FAIL ena_bus t=%0t got=%0b exp=%0b", $time, ena_bus, m_ena);
    end
    checks++;
    if (bus_sel !== m_sel) begin
      errors++; $display("FAIL bus_sel t=%0t got=%02h exp=%02h", $time, bus_sel, m_sel);
    end
    checks++;
    if (slot_idx !== 4'(m_slot)) begin
      errors++; $display("FAIL slot_idx t=%0t got=%0d exp=%0d", $time, slot_idx, m_slot);
    end
    checks++;
    if (donated !== m_don) begin
      errors++; $display("FAIL donated t=%0t got=%0b exp=%0b", $time, donated, m_don);
    end
    @(negedge clk_cog);
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (ena_bus !== 1'b0 || bus_sel !== 8'h00 || slot_idx !== 4'd15 || donated !== 1'b0) begin
      errors++;
      $display("FAIL %s got ena=%0b sel=%02h idx=%0d don=%0b exp ena=0 sel=00 idx=15 don=0",
               tag, ena_bus, bus_sel, slot_idx, donated);
    end
  endtask

  task automatic test_reset();
    nres = 1'b0;
    #1;
    check_reset_vals("reset_values");
    model_reset();
    @(negedge clk_cog);
    nres = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_legacy();
    int n = 0;
    cog_ena = 8'hFF; mode_skip = 0; cog_req = 8'h00;
    for (int t = 0; t < 60 && n < 10; t++) begin
      cyc();
      if (m_adv) begin
        checks++;
        if (bus_sel !== (8'h01 << (m_slot % 8))) begin
          errors++; $display("FAIL legacy_rot slot=%0d got=%02h exp=%02h", m_slot, bus_sel, 8'h01 << (m_slot % 8));
        end
        n++;
      end
    end
    checks++;
    if (n < 10) begin errors++; $display("FAIL legacy_timeout got=%0d adv exp=10", n); end
  endtask

  task automatic test_table();
    logic [3:0] wr [4];
    logic [7:0] exp_sel [4];
    int n = 0;
    wr[0] = 4'hD; wr[1] = 4'hD; wr[2] = 4'hA; wr[3] = 4'h6;
    exp_sel[0] = 8'h20; exp_sel[1] = 8'h20; exp_sel[2] = 8'h04; exp_sel[3] = 8'h00;
    len_we = 1; len_data = 4'd3;
    cyc();
    len_we = 0;
    for (int i = 0; i < 4; i++) begin
      tbl_we = 1; tbl_addr = 4'(i); tbl_data = wr[i];
      cyc();
    end
    tbl_we = 0;
    repeat (16) cyc();
    for (int t = 0; t < 60 && n < 8; t++) begin
      cyc();
      if (m_adv) begin
        checks++;
        if (bus_sel !== exp_sel[m_slot % 4]) begin
          errors++; $display("FAIL table_sel slot=%0d got=%02h exp=%02h", m_slot, bus_sel, exp_sel[m_slot % 4]);
        end
        n++;
      end
    end
    checks++;
    if (n < 8) begin errors++; $display("FAIL table_timeout got=%0d adv exp=8", n); end
  endtask

  task automatic test_donate();
    logic [7:0] exp_sel [3];
    int n = 0;
    exp_sel[0] = 8'h01; exp_sel[1] = 8'h80; exp_sel[2] = 8'h01;
    mode_skip = 1; cog_req = 8'h81;
    for (int t = 0; t < 80 && n < 3; t++) begin
      cyc();
      if (m_adv && m_slot == 3) begin
        checks++;
        if (bus_sel !== exp_sel[n] || donated !== 1'b1) begin
          errors++; $display("FAIL donate_alt n=%0d got sel=%02h don=%0b exp sel=%02h don=1", n, bus_sel, donated, exp_sel[n]);
        end
        n++;
      end
    end
    cog_req = 8'h00;
    n = 0;
    for (int t = 0; t < 40 && n < 1; t++) begin
      cyc();
      if (m_adv && m_slot == 3) begin
        checks++;
        if (bus_sel !== 8'h00 || donated !== 1'b0) begin
          errors++; $display("FAIL donate_none got sel=%02h don=%0b exp sel=00 don=0", bus_sel, donated);
        end
        n++;
      end
    end
    checks++;
    if (n < 1) begin errors++; $display("FAIL donate_timeout got=%0d exp=1", n); end
  endtask

  task automatic test_stopped_cog();
    bit seen0 = 0, seen2 = 0;
    test_reset();
    cog_ena = 8'hFE; mode_skip = 1; cog_req = 8'h04;
    for (int t = 0; t < 40 && !(seen0 && seen2); t++) begin
      cyc();
      if (m_adv && m_slot == 0 && !seen0) begin
        seen0 = 1; checks++;
        if (bus_sel !== 8'h04 || donated !== 1'b1) begin
          errors++; $display("FAIL stopped_slot0 got sel=%02h don=%0b exp sel=04 don=1", bus_sel, donated);
        end
      end
      if (m_adv && m_slot == 2 && !seen2) begin
        seen2 = 1; checks++;
        if (bus_sel !== 8'h04 || donated !== 1'b0) begin
          errors++; $display("FAIL stopped_slot2 got sel=%02h don=%0b exp sel=04 don=0", bus_sel, donated);
        end
      end
    end
    checks++;
    if (!(seen0 && seen2)) begin errors++; $display("FAIL stopped_timeout got=%0b%0b exp=11", seen0, seen2); end
  endtask

  task automatic test_back_to_back_write();
    bit hit = 0, seen = 0;
    cog_ena = 8'hFF; mode_skip = 0; cog_req = 8'h00;
    for (int t = 0; t < 40 && !hit; t++) begin
      if (m_ena && m_slot >= m_len) begin
        tbl_we = 1; tbl_addr = 4'd0; tbl_data = 4'hB;
        cyc();
        tbl_we = 0;
        hit = 1; checks++;
        if (bus_sel !== 8'h01 || slot_idx !== 4'd0) begin
          errors++; $display("FAIL collide_old got sel=%02h idx=%0d exp sel=01 idx=0", bus_sel, slot_idx);
        end
      end else begin
        cyc();
      end
    end
    for (int t = 0; t < 40 && hit && !seen; t++) begin
      cyc();
      if (m_adv && m_slot == 0) begin
        seen = 1; checks++;
        if (bus_sel !== 8'h08) begin
          errors++; $display("FAIL collide_new got sel=%02h exp=08", bus_sel);
        end
      end
    end
    checks++;
    if (!(hit && seen)) begin errors++; $display("FAIL collide_timeout got=%0b%0b exp=11", hit, seen); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0, seen = 0;
    for (int t = 0; t < 40 && !hit; t++) begin
      cyc();
      if (m_adv && m_slot == 5) hit = 1;
    end
    #2 nres = 1'b0;
    #1;
    check_reset_vals("midslot_reset");
    model_reset();
    @(negedge clk_cog);
    nres = 1'b1;
    for (int t = 0; t < 40 && !seen; t++) begin
      cyc();
      if (m_adv) begin
        seen = 1; checks++;
        if (bus_sel !== 8'h01 || slot_idx !== 4'd0) begin
          errors++; $display("FAIL restart got sel=%02h idx=%0d exp sel=01 idx=0", bus_sel, slot_idx);
        end
      end
    end
    checks++;
    if (!(hit && seen)) begin errors++; $display("FAIL midreset_timeout got=%0b%0b exp=11", hit, seen); end
    repeat (20) cyc();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      cog_ena   = 8'($urandom);
      cog_req   = 8'($urandom);
      mode_skip = 1'($urandom);
      tbl_we    = ($urandom_range(0, 5) == 0);
      tbl_addr  = 4'($urandom);
      tbl_data  = 4'($urandom);
      len_we    = ($urandom_range(0, 15) == 0);
      len_data  = 4'($urandom);
      cyc();
    end
    tbl_we = 0; len_we = 0;
  endtask

  initial begin
    nres = 1'b0;
    cog_ena = 8'hFF; cog_req = 8'h00; mode_skip = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    len_we = 1'b0; len_data = '0;
    model_reset();
    @(negedge clk_cog);
    test_reset();
    test_legacy();
    test_table();
    test_donate();
    test_stopped_cog();
    test_back_to_back_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
